// File: rtl/stack_memory_if.sv
// Push/pop handshake between the RPN memory controller (master) and the operand stack (slave).
interface stack_memory_if #(
  parameter int WIDTH = 32,
  parameter int PTR_W = 4
);
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] memIn;
  logic [WIDTH-1:0] memOut;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, err_clr, memIn,
    input  memOut, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, err_clr, memIn,
    output memOut, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_memory.sv
// LIFO operand stack with a registered show-ahead top (memOut), saturating count
// and sticky overflow/underflow flags.
module stack_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  stack_memory_if.slave  bus
);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_TWO = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] IDX_TWO = PTR_W'(2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] idx_free, idx_top, idx_below;
  logic             is_empty, is_full;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_MAX);
  // When full the low bits wrap to 0, so top/below still land on DEPTH-1/DEPTH-2.
  assign idx_free  = count_q[PTR_W-1:0];
  assign idx_top   = idx_free - IDX_ONE;
  assign idx_below = idx_free - IDX_TWO;

  always_comb begin
    count_d = count_q;
    top_d   = top_q;
    ovf_d   = ovf_q & ~bus.err_clr;
    unf_d   = unf_q & ~bus.err_clr;
    wr_en   = 1'b0;
    wr_idx  = idx_free;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          top_d   = bus.memIn;
          count_d = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
          top_d   = (count_q >= CNT_TWO) ? mem_q[idx_below] : '0;
        end
      end
      2'b11: begin
        // Replace-top; on an empty stack this degenerates to a plain push.
        wr_en = 1'b1;
        top_d = bus.memIn;
        if (is_empty) count_d = CNT_ONE;
        else          wr_idx  = idx_top;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= bus.memIn;
  end

  assign bus.memOut    = top_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
